// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM state, owner id and the latched request.
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic                  we;
    logic [ARB_BE_W-1:0]   be;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } arb_req_t;

  // Timeout counter is at least 8 bits wide, wider only when the limit needs it.
  function automatic int timer_width(input int limit);
    return ($clog2(limit + 1) > 8) ? $clog2(limit + 1) : 8;
  endfunction

endpackage

// File: rtl/arb_timer.sv
// Transaction watchdog: counts cycles while enabled and flags the last allowed cycle.
module arb_timer #(
  parameter int LIMIT = 255,
  parameter int W     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  // High in the LIMIT-th busy cycle so the abort edge lands LIMIT cycles after entering REQ.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one fetch / load-store arbiter onto one memory port, one outstanding transaction.
// Build option MEM_ARB_ROUND_ROBIN_EN: alternate owners on ties; otherwise D always wins ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_rsp_valid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_rsp_valid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_err,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  localparam int TMR_W = timer_width(TIMEOUT);

  // Handshake: a request transfers on a cycle where x_req_valid and x_req_ready are both high;
  // ready is offered only in IDLE and only to the selected requester, which must otherwise hold.

  arb_state_e          state;
  arb_owner_e          owner;
  arb_owner_e          last_owner;
  arb_owner_e          grant;
  arb_req_t            req_q;
  arb_req_t            req_next;
  logic                accept;
  logic                in_flight;
  logic                expired;
  logic                rsp_fire;
  logic                rsp_err;
  logic [DATA_W-1:0]   rsp_data;

  always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (i_req_valid && d_req_valid) begin
      grant = (last_owner == OWN_I) ? OWN_D : OWN_I;
    end else begin
      grant = d_req_valid ? OWN_D : OWN_I;
    end
`else
    grant = d_req_valid ? OWN_D : OWN_I;
`endif
  end

  // Reset is folded in so no handshake is ever reported while the block is being cleared.
  assign i_req_ready = !reset && (state == IDLE) && i_req_valid && (grant == OWN_I);
  assign d_req_ready = !reset && (state == IDLE) && d_req_valid && (grant == OWN_D);
  assign accept      = i_req_ready || d_req_ready;

  always_comb begin
    req_next = '0;
    if (grant == OWN_D) begin
      req_next.we    = d_we;
      req_next.be    = d_be;
      req_next.addr  = d_addr;
      req_next.wdata = d_wdata;
    end else begin
      req_next.we    = 1'b0;
      req_next.be    = '1;
      req_next.addr  = i_addr;
    end
  end

  assign in_flight = (state == REQ) || (state == WAIT);

  arb_timer #(
    .LIMIT (TIMEOUT),
    .W     (TMR_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .enable  (in_flight),
    .expired (expired)
  );

  // A real memory answer in WAIT beats a watchdog expiry in the same cycle.
  always_comb begin
    rsp_fire = 1'b0;
    rsp_err  = 1'b0;
    rsp_data = '0;
    if ((state == WAIT) && m_rsp_valid) begin
      rsp_fire = 1'b1;
      rsp_err  = m_err;
      rsp_data = m_rdata;
    end else if (in_flight && expired) begin
      rsp_fire = 1'b1;
      rsp_err  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_I;
      last_owner  <= OWN_I;
      req_q       <= '0;
      m_req_valid <= 1'b0;
      i_rsp_valid <= 1'b0;
      i_rdata     <= '0;
      i_err       <= 1'b0;
      d_rsp_valid <= 1'b0;
      d_rdata     <= '0;
      d_err       <= 1'b0;
    end else begin
      i_rsp_valid <= 1'b0;
      i_err       <= 1'b0;
      d_rsp_valid <= 1'b0;
      d_err       <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            owner       <= grant;
            req_q       <= req_next;
            m_req_valid <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (rsp_fire) begin
            m_req_valid <= 1'b0;
            state       <= RESP;
          end else if (m_req_ready) begin
            m_req_valid <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (rsp_fire) begin
            state <= RESP;
          end
        end
        RESP: begin
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Only the owner's response port moves; the other keeps its last data and stays invalid.
      if (rsp_fire) begin
        if (owner == OWN_I) begin
          i_rsp_valid <= 1'b1;
          i_rdata     <= rsp_data;
          i_err       <= rsp_err;
        end else begin
          d_rsp_valid <= 1'b1;
          d_rdata     <= rsp_data;
          d_err       <= rsp_err;
        end
      end
    end
  end

  assign m_we      = req_q.we;
  assign m_be      = req_q.be;
  assign m_addr    = req_q.addr;
  assign m_wdata   = req_q.wdata;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, response scoreboard, directed tests.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 10;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam logic [3:0] TIE_GRANTS = 4'b0101;
  localparam bit         RR_MODE    = 1'b1;
`else
  localparam logic [3:0] TIE_GRANTS = 4'b1111;
  localparam bit         RR_MODE    = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          i_req_valid, i_req_ready;
  logic [AW-1:0] i_addr;
  logic          i_rsp_valid;
  logic [DW-1:0] i_rdata;
  logic          i_err;
  logic          d_req_valid, d_req_ready, d_we;
  logic [BW-1:0] d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_rsp_valid;
  logic [DW-1:0] d_rdata;
  logic          d_err;
  logic          m_req_valid, m_req_ready, m_we;
  logic [BW-1:0] m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_rsp_valid;
  logic [DW-1:0] m_rdata;
  logic          m_err;
  logic          busy;
  logic [1:0]    dbg_state;

  mem_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req_valid (i_req_valid),
    .i_req_ready (i_req_ready),
    .i_addr      (i_addr),
    .i_rsp_valid (i_rsp_valid),
    .i_rdata     (i_rdata),
    .i_err       (i_err),
    .d_req_valid (d_req_valid),
    .d_req_ready (d_req_ready),
    .d_we        (d_we),
    .d_be        (d_be),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rsp_valid (d_rsp_valid),
    .d_rdata     (d_rdata),
    .d_err       (d_err),
    .m_req_valid (m_req_valid),
    .m_req_ready (m_req_ready),
    .m_we        (m_we),
    .m_be        (m_be),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_rsp_valid (m_rsp_valid),
    .m_rdata     (m_rdata),
    .m_err       (m_err),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory responder ----------------
  int            mem_ready_delay = 0;
  int            mem_rsp_delay   = 0;
  bit            mem_respond     = 1'b1;
  logic [DW-1:0] mem_rdata_v     = '0;
  logic          mem_err_v       = 1'b0;
  bit            mem_busy        = 1'b0;
  int            mem_cnt         = 0;
  bit            stray_req       = 1'b0;
  logic [DW-1:0] stray_data      = '0;

  task automatic mem_clear();
    mem_busy = 1'b0;
    mem_cnt  = 0;
  endtask

  initial begin
    m_req_ready = 1'b0;
    m_rsp_valid = 1'b0;
    m_rdata     = '0;
    m_err       = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_req_ready = 1'b0;
      m_rsp_valid = 1'b0;
      m_rdata     = '0;
      m_err       = 1'b0;
      if (stray_req) begin
        m_rsp_valid = 1'b1;
        m_rdata     = stray_data;
        stray_req   = 1'b0;
      end else if (!mem_busy) begin
        if (m_req_valid) begin
          if (mem_cnt >= mem_ready_delay) begin
            m_req_ready = 1'b1;
            mem_busy    = 1'b1;
            mem_cnt     = 0;
          end else begin
            mem_cnt++;
          end
        end
      end else if (mem_respond) begin
        if (mem_cnt >= mem_rsp_delay) begin
          m_rsp_valid = 1'b1;
          m_rdata     = mem_rdata_v;
          m_err       = mem_err_v;
          mem_busy    = 1'b0;
          mem_cnt     = 0;
        end else begin
          mem_cnt++;
        end
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  // One open transaction at a time: accepted -> memory took it -> answered -> reported.
  bit            tx_open     = 1'b0;
  bit            tx_granted  = 1'b0;
  bit            tx_answered = 1'b0;
  int            tx_age      = 0;
  bit            tx_is_d     = 1'b0;
  bit            last_was_d  = 1'b0;
  logic          tx_we;
  logic [BW-1:0] tx_be;
  logic [AW-1:0] tx_addr;
  logic [DW-1:0] tx_wdata;
  logic [DW-1:0] tx_rdata;
  logic          tx_err;
  bit            pick_d, exp_i_rdy, exp_d_rdy, exp_mreq;

  always @(negedge clk) begin
    if (i_req_valid && d_req_valid) pick_d = RR_MODE ? !last_was_d : 1'b1;
    else                            pick_d = d_req_valid;
    exp_i_rdy = !reset && !tx_open && i_req_valid && !pick_d;
    exp_d_rdy = !reset && !tx_open && d_req_valid && pick_d;
    exp_mreq  = tx_open && !tx_granted && !tx_answered;

    check("i_req_ready", i_req_ready, exp_i_rdy);
    check("d_req_ready", d_req_ready, exp_d_rdy);
    check("busy", busy, tx_open);
    check("m_req_valid", m_req_valid, exp_mreq);
    if (exp_mreq) begin
      check("m_addr", m_addr, tx_addr);
      check("m_we", m_we, tx_we);
      check("m_be", m_be, tx_be);
      if (tx_is_d) check("m_wdata", m_wdata, tx_wdata);
    end
    check("i_rsp_valid", i_rsp_valid, tx_answered && !tx_is_d);
    check("d_rsp_valid", d_rsp_valid, tx_answered && tx_is_d);
    if (tx_answered && !tx_is_d) begin
      check("i_rdata", i_rdata, tx_rdata);
      check("i_err", i_err, tx_err);
    end
    if (tx_answered && tx_is_d) begin
      check("d_rdata", d_rdata, tx_rdata);
      check("d_err", d_err, tx_err);
    end

    // what the coming clock edge must do
    if (reset) begin
      tx_open = 0; tx_granted = 0; tx_answered = 0; last_was_d = 0;
    end else if (!tx_open) begin
      if (exp_i_rdy || exp_d_rdy) begin
        tx_open = 1; tx_granted = 0; tx_answered = 0; tx_age = 0;
        tx_is_d = exp_d_rdy;
        tx_we    = exp_d_rdy ? d_we    : 1'b0;
        tx_be    = exp_d_rdy ? d_be    : {BW{1'b1}};
        tx_addr  = exp_d_rdy ? d_addr  : i_addr;
        tx_wdata = d_wdata;
      end
    end else if (tx_answered) begin
      last_was_d = tx_is_d;
      tx_open = 0; tx_answered = 0; tx_granted = 0;
    end else begin
      if (tx_granted && m_rsp_valid) begin
        tx_rdata = m_rdata; tx_err = m_err; tx_answered = 1;
      end else if (tx_age == TO - 1) begin
        tx_rdata = '0; tx_err = 1'b1; tx_answered = 1;
      end else if (!tx_granted && m_req_ready) begin
        tx_granted = 1;
      end
      tx_age++;
    end
  end

  // ---------------- scoreboard (hand-computed responses) ----------------
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] exp_item;
  logic [DW+1:0] act_item;
  bit            grant_log[$];
  int            acc_cyc   = 0;
  int            rsp_cyc   = 0;
  int            rsp_count = 0;

  always @(negedge clk) begin
    if (!reset && i_req_valid && i_req_ready) begin
      acc_cyc = cyc; grant_log.push_back(1'b0);
    end
    if (!reset && d_req_valid && d_req_ready) begin
      acc_cyc = cyc; grant_log.push_back(1'b1);
    end
    if (i_rsp_valid || d_rsp_valid) begin
      rsp_cyc = cyc;
      rsp_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {d_rsp_valid, i_rsp_valid}, 2'b00);
      end else begin
        exp_item = exp_q.pop_front();
        act_item = d_rsp_valid ? {1'b1, d_err, d_rdata} : {1'b0, i_err, i_rdata};
        check("rsp_scoreboard", act_item, exp_item);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic issue_i(input logic [AW-1:0] a);
    int n = 0;
    @(posedge clk); #1;
    i_req_valid = 1'b1;
    i_addr      = a;
    do begin @(negedge clk); n++; end while (!i_req_ready && n < 20);
    check("i_accept", i_req_ready, 1'b1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic issue_d(input logic we, input logic [BW-1:0] be, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd);
    int n = 0;
    @(posedge clk); #1;
    d_req_valid = 1'b1;
    d_we = we; d_be = be; d_addr = a; d_wdata = wd;
    do begin @(negedge clk); n++; end while (!d_req_ready && n < 20);
    check("d_accept", d_req_ready, 1'b1);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max);
    int start = rsp_count;
    int n = 0;
    while (rsp_count == start && n < max) begin
      @(negedge clk); #1;
      n++;
    end
    check("rsp_arrival", rsp_count - start, 1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    reset = 1'b1;
    i_req_valid = 0; i_addr = '0;
    d_req_valid = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk); #1;
    check("rst_m_addr", m_addr, 32'h0);
    check("rst_m_we", m_we, 1'b0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);

    // single fetch
    mem_ready_delay = 0; mem_rsp_delay = 0; mem_respond = 1;
    mem_rdata_v = 32'h0050_0093; mem_err_v = 0;
    exp_q.push_back({1'b0, 1'b0, 32'h0050_0093});
    issue_i(32'h100);
    wait_rsp(20);
    check("fetch_latency", rsp_cyc - acc_cyc, 3);

    // store with memory stalling three cycles
    mem_ready_delay = 3; mem_rdata_v = 32'h0;
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    issue_d(1'b1, 4'b0011, 32'h2004, 32'hDEAD_BEEF);
    @(negedge clk); #1;
    check("store_m_addr", m_addr, 32'h2004);
    check("store_m_be", m_be, 4'b0011);
    check("store_m_wdata", m_wdata, 32'hDEAD_BEEF);
    check("store_m_we", m_we, 1'b1);
    wait_rsp(20);
    check("store_latency", rsp_cyc - acc_cyc, 6);
    check("store_hold_addr", m_addr, 32'h2004);

    // load returning a memory error
    mem_ready_delay = 0; mem_rdata_v = 32'hCAFE_0001; mem_err_v = 1;
    exp_q.push_back({1'b1, 1'b1, 32'hCAFE_0001});
    issue_d(1'b0, 4'hF, 32'h3000, 32'h0);
    wait_rsp(20);
    check("err_latency", rsp_cyc - acc_cyc, 3);
    mem_err_v = 0;

    // watchdog, then a stray response two cycles later
    mem_respond = 0;
    exp_q.push_back({1'b1, 1'b1, 32'h0});
    issue_d(1'b0, 4'hF, 32'h4000, 32'h0);
    wait_rsp(30);
    check("timeout_latency", rsp_cyc - acc_cyc, TO + 1);
    @(negedge clk);
    stray_data = 32'h5555_AAAA;
    stray_req  = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    mem_clear();

    // reset while waiting on memory, late answer, then a clean fetch
    issue_i(32'h300);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    check("wait_rst_m_req_valid", m_req_valid, 1'b0);
    check("wait_rst_busy", busy, 1'b0);
    check("wait_rst_m_addr", m_addr, 32'h0);
    check("wait_rst_i_rsp", i_rsp_valid, 1'b0);
    stray_data = 32'h7777_0000;
    stray_req  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    mem_clear();
    mem_respond = 1; mem_rdata_v = 32'h0000_0013;
    exp_q.push_back({1'b0, 1'b0, 32'h0000_0013});
    issue_i(32'h400);
    wait_rsp(20);
    check("post_rst_latency", rsp_cyc - acc_cyc, 3);

    // both requesters valid every cycle for four transactions
    do_reset(2);
    @(negedge clk); #1;
    mem_clear();
    mem_rdata_v = 32'h1111_0000;
    for (int k = 0; k < 4; k++) exp_q.push_back({TIE_GRANTS[k], 1'b0, 32'h1111_0000});
    grant_log.delete();
    @(posedge clk); #1;
    i_req_valid = 1; i_addr = 32'h500;
    d_req_valid = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h600; d_wdata = '0;
    begin
      int n = 0;
      while (grant_log.size() < 4 && n < 60) begin
        @(negedge clk); #1;
        n++;
      end
    end
    @(posedge clk); #1;
    i_req_valid = 0; d_req_valid = 0;
    repeat (8) @(negedge clk);
    #1;
    check("tie_grant_count", grant_log.size(), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++) begin
      check($sformatf("tie_grant_%0d", k), grant_log[k], TIE_GRANTS[k]);
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
